// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared widths, the sequential PC step and the fetch FSM state type used by
// instr_fetch_unit and fetch_out_reg.
// ---------------------------------------------------------------------------
package fetch_pkg;
    localparam int ADDR_W  = 64;
    localparam int INSTR_W = 32;
    localparam logic [ADDR_W-1:0] PC_STEP = 64'd4;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_t;
endpackage

// File: rtl/fetch_out_reg.sv
// ---------------------------------------------------------------------------
// fetch_out_reg
// Single-entry output stage toward decode. Holds one fetched instruction and
// the address it came from.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   load              capture instr_in/pc_in and mark valid
//   flush             drop the held entry (wins over load)
//   instr_in, pc_in   word and address being captured
//   valid, instr, pc  registered output entry
// ---------------------------------------------------------------------------
module fetch_out_reg
    import fetch_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               flush,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic [ADDR_W-1:0]  pc_in,
    output logic               valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  pc
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            instr <= '0;
            pc    <= '0;
        end else if (flush) begin
            // Only the valid flag is cleared; stale data is harmless.
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            instr <= instr_in;
            pc    <= pc_in;
        end
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
// Owns the PC, presents it to the combinational instruction memory every
// cycle and registers the returned word into a one-entry stage toward decode.
// Branch redirects from execute override sequential fetch; a misaligned or
// out-of-range PC parks the unit in a sticky FAULT state until redirected.
// Ports:
//   clk, reset     clock, asynchronous active-high reset
//   imem_addr      byte address to instruction memory (== pc_q)
//   imem_instr     word returned by memory in the same cycle
//   redirect       taken branch/jump, redirect_pc is the new PC
//   dec_valid      dec_instr/dec_pc hold a fetched instruction
//   dec_ready      decode accepts this cycle
//   dec_instr      fetched instruction
//   dec_pc         address dec_instr was fetched from
//   fault          sticky fetch fault
//   fsm_state      current FSM state (0 = RUN, 1 = FAULT), for observation
// Optional: define FETCH_TRACE_EN to print every accepted instruction and the
// running accepted-instruction count when FAULT is entered.
//
// Handshake: an instruction transfers to decode on a cycle where
// dec_valid && dec_ready at the rising edge. dec_valid never drops and
// dec_instr/dec_pc never change while dec_valid && !dec_ready, except that a
// redirect (flush) or reset may retract the entry.
// ---------------------------------------------------------------------------
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC  = 64'd0,
    parameter int                MEM_BYTES = 1024
) (
    input  logic               clk,
    input  logic               reset,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               dec_valid,
    input  logic               dec_ready,
    output logic [INSTR_W-1:0] dec_instr,
    output logic [ADDR_W-1:0]  dec_pc,
    output logic               fault,
    output logic               fsm_state
);
    localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_BYTES);

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W:0]   pc_last;
    logic              pc_ok;
    logic              out_free;
    logic              load;
    logic              flush;

    // Last byte of the word computed one bit wider so the range test never wraps.
    always_comb begin
        pc_last  = {1'b0, pc_q} + (ADDR_W+1)'(3);
        pc_ok    = (pc_q[1:0] == 2'b00) && (pc_last < MEM_LIMIT);
        out_free = !dec_valid || dec_ready;
        load     = (state == RUN) && !redirect && out_free && pc_ok;
        flush    = redirect || ((state == RUN) && out_free && !pc_ok);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
            pc_q  <= RESET_PC;
            fault <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (redirect) begin
                        pc_q <= redirect_pc;
                    end else if (out_free && pc_ok) begin
                        pc_q <= pc_q + PC_STEP;
                    end else if (out_free) begin
                        state <= FAULT;
                        fault <= 1'b1;
                    end
                end
                FAULT: begin
                    if (redirect) begin
                        pc_q  <= redirect_pc;
                        state <= RUN;
                        fault <= 1'b0;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    assign imem_addr = pc_q;
    assign fsm_state = state;

    fetch_out_reg u_out (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .flush    (flush),
        .instr_in (imem_instr),
        .pc_in    (pc_q),
        .valid    (dec_valid),
        .instr    (dec_instr),
        .pc       (dec_pc)
    );

`ifdef FETCH_TRACE_EN
    logic [31:0] accepted_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            accepted_cnt <= '0;
        end else begin
            if (dec_valid && dec_ready) begin
                accepted_cnt <= accepted_cnt + 32'd1;
                $display("%t FETCH pc=%h instr=%h", $time, dec_pc, dec_instr);
            end
            if (state == RUN && !redirect && out_free && !pc_ok) begin
                $display("%t FETCH fault at pc=%h accepted=%0d", $time, pc_q, accepted_cnt);
            end
        end
    end
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
    logic        clk;
    logic        reset;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [63:0] dec_pc;
    logic        fault;
    logic        fsm_state;

    int errors;
    int checks;

    instr_fetch_unit #(.RESET_PC(64'd0), .MEM_BYTES(1024)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_addr   (imem_addr),
        .imem_instr  (imem_instr),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .dec_valid   (dec_valid),
        .dec_ready   (dec_ready),
        .dec_instr   (dec_instr),
        .dec_pc      (dec_pc),
        .fault       (fault),
        .fsm_state   (fsm_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory model: word at address a is {16'hCAFE, a[15:0]}.
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return {16'hCAFE, a[15:0]};
    endfunction
    assign imem_instr = mem_word(imem_addr);

    // Advance one clock, then settle 1 time unit past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_valid(input string tag, input logic [63:0] pc, input logic [63:0] next_addr);
        chk({tag, "_valid"}, {63'd0, dec_valid}, 64'd1);
        chk({tag, "_pc"}, dec_pc, pc);
        chk({tag, "_instr"}, {32'd0, dec_instr}, {32'd0, mem_word(pc)});
        chk({tag, "_addr"}, imem_addr, next_addr);
    endtask

    task automatic chk_idle(input string tag, input logic [63:0] addr, input logic exp_fault);
        chk({tag, "_valid"}, {63'd0, dec_valid}, 64'd0);
        chk({tag, "_addr"}, imem_addr, addr);
        chk({tag, "_fault"}, {63'd0, fault}, {63'd0, exp_fault});
        chk({tag, "_state"}, {63'd0, fsm_state}, {63'd0, exp_fault});
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 64'd0;
        dec_ready   = 1'b1;

        // 1: reset held 3 cycles, then sequential fetch
        step(); step(); step();
        chk_idle("rst", 64'd0, 1'b0);
        chk("rst_dec_pc", dec_pc, 64'd0);
        chk("rst_dec_instr", {32'd0, dec_instr}, 64'd0);
        reset = 1'b0;
        #1;
        chk_idle("post_rst", 64'd0, 1'b0);
        step(); chk_valid("seq0", 64'd0, 64'd4);
        step(); chk_valid("seq4", 64'd4, 64'd8);
        step(); chk_valid("seq8", 64'd8, 64'd12);

        // 2: stall three cycles with dec_pc=8
        dec_ready = 1'b0;
        step(); chk_valid("stall1", 64'd8, 64'd12);
        step(); chk_valid("stall2", 64'd8, 64'd12);
        step(); chk_valid("stall3", 64'd8, 64'd12);
        dec_ready = 1'b1;
        step(); chk_valid("rel12", 64'd12, 64'd16);
        step(); chk_valid("rel16", 64'd16, 64'd20);

        // 3: redirect to 0x40 costs one bubble
        redirect = 1'b1; redirect_pc = 64'h40;
        step(); chk_idle("redir_bubble", 64'h40, 1'b0);
        redirect = 1'b0;
        step(); chk_valid("redir40", 64'h40, 64'h44);

        // 4: misaligned redirect faults, redirect clears it
        redirect = 1'b1; redirect_pc = 64'h42;
        step(); chk_idle("mis_load", 64'h42, 1'b0);
        redirect = 1'b0;
        step(); chk_idle("mis_fault", 64'h42, 1'b1);
        step(); chk_idle("mis_hold", 64'h42, 1'b1);
        redirect = 1'b1; redirect_pc = 64'h10;
        step(); chk_idle("fault_clr", 64'h10, 1'b0);
        redirect = 1'b0;
        step(); chk_valid("after_clr", 64'h10, 64'h14);

        // 5: run into the top of memory
        redirect = 1'b1; redirect_pc = 64'd1012;
        step(); chk_idle("top_redir", 64'd1012, 1'b0);
        redirect = 1'b0;
        step(); chk_valid("top1012", 64'd1012, 64'd1016);
        step(); chk_valid("top1016", 64'd1016, 64'd1020);
        step(); chk_valid("top1020", 64'd1020, 64'd1024);
        step(); chk_idle("oor_fault", 64'd1024, 1'b1);
        step(); chk_idle("oor_hold", 64'd1024, 1'b1);

        // Huge address: range test must not wrap around
        redirect = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        step(); chk_idle("huge_load", 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
        redirect = 1'b0;
        step(); chk_idle("huge_fault", 64'hFFFF_FFFF_FFFF_FFFC, 1'b1);

        // 6: redirect beats stall, then async reset mid-stall
        redirect = 1'b1; redirect_pc = 64'h20;
        step(); chk_idle("r20", 64'h20, 1'b0);
        redirect = 1'b0;
        step(); chk_valid("r20v", 64'h20, 64'h24);
        dec_ready = 1'b0;
        redirect = 1'b1; redirect_pc = 64'h80;
        step(); chk_idle("redir_stall", 64'h80, 1'b0);
        redirect = 1'b0;
        step(); chk_valid("r80", 64'h80, 64'h84);
        step(); chk_valid("r80_stall", 64'h80, 64'h84);
        #2;
        reset = 1'b1;
        #1;
        chk_idle("async_rst", 64'd0, 1'b0);
        chk("async_rst_pc", dec_pc, 64'd0);
        step();
        reset = 1'b0;
        dec_ready = 1'b1;
        step(); chk_valid("rst_restart", 64'd0, 64'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #20000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
